// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: default widths, the NOP encoding and FSM states.
package inst_fetch_pkg;

  localparam int PC_W_DEF   = 7;
  localparam int INST_W_DEF = 16;

  localparam logic [15:0] NOP_INST = 16'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Program counter with its next-PC mux: reset, branch redirect, stall, halt-hold and increment.
module inst_fetch_pc_reg #(
  parameter int PC_W      = 7,
  parameter int LAST_ADDR = 127
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halted,
  output logic [PC_W-1:0] pc,
  output logic            at_last
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(LAST_ADDR);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;

  assign pc      = pc_reg;
  assign at_last = (pc_reg == LAST_PC);

  // The last address holds the PC so the increment never wraps out of a halt.
  always_comb begin
    pc_next = pc_reg;
    if (branch_taken) begin
      pc_next = branch_target;
    end else if (stall || halted || at_last) begin
      pc_next = pc_reg;
    end else begin
      pc_next = pc_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, IF/ID register and RUN/HALT control for a 128-word ROM.
// Optional performance counters are enabled by defining INST_FETCH_PERF_CNT_EN.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int INST_W    = INST_W_DEF,
  parameter int LAST_ADDR = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_taken_i,
  input  logic [PC_W-1:0]   branch_target_i,
  output logic [PC_W-1:0]   addr_o,
  input  logic [INST_W-1:0] inst_i,
  output logic [PC_W-1:0]   if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o,
  output logic              halted_o
`ifdef INST_FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);

  fetch_state_t      state_reg, state_next;
  logic [PC_W-1:0]   if_pc_reg, if_pc_next;
  logic [INST_W-1:0] if_inst_reg, if_inst_next;
  logic              if_valid_reg, if_valid_next;
  logic              load_fetch;
  logic              at_last;
  logic [PC_W-1:0]   pc;

  inst_fetch_pc_reg #(
    .PC_W      (PC_W),
    .LAST_ADDR (LAST_ADDR)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall_i),
    .branch_taken  (branch_taken_i),
    .branch_target (branch_target_i),
    .halted        (state_reg == HALT),
    .pc            (pc),
    .at_last       (at_last)
  );

  // Branch outranks stall so a flush is never lost while decode is blocked.
  always_comb begin
    state_next    = state_reg;
    if_pc_next    = if_pc_reg;
    if_inst_next  = if_inst_reg;
    if_valid_next = if_valid_reg;
    load_fetch    = 1'b0;
    if (branch_taken_i) begin
      state_next    = RUN;
      if_valid_next = 1'b0;
    end else if (!stall_i) begin
      if (state_reg == RUN) begin
        load_fetch    = 1'b1;
        if_pc_next    = pc;
        if_inst_next  = inst_i;
        if_valid_next = 1'b1;
        if (at_last) begin
          state_next = HALT;
        end
      end else begin
        if_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      if_pc_reg    <= '0;
      if_inst_reg  <= INST_W'(NOP_INST);
      if_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      if_pc_reg    <= if_pc_next;
      if_inst_reg  <= if_inst_next;
      if_valid_reg <= if_valid_next;
    end
  end

  assign addr_o     = pc;
  assign if_pc_o    = if_pc_reg;
  assign if_inst_o  = if_inst_reg;
  assign if_valid_o = if_valid_reg;
  assign halted_o   = (state_reg == HALT);

`ifdef INST_FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_reg;
  logic [15:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (load_fetch && fetch_cnt_reg != 16'hFFFF) begin
        fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
      end
      if (branch_taken_i && flush_cnt_reg != 16'hFFFF) begin
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`else
  logic unused_load_fetch;
  assign unused_load_fetch = load_fetch;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised scoreboard bench for inst_fetch, checked against a rule-level fetch model.
module tb_inst_fetch;

  localparam int PC_W      = 7;
  localparam int INST_W    = 16;
  localparam int LAST_ADDR = 10;
  localparam int DEPTH     = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              stall_i;
  logic              branch_taken_i;
  logic [PC_W-1:0]   branch_target_i;
  logic [PC_W-1:0]   addr_o;
  logic [INST_W-1:0] inst_i;
  logic [PC_W-1:0]   if_pc_o;
  logic [INST_W-1:0] if_inst_o;
  logic              if_valid_o;
  logic              halted_o;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [15:0]       fetch_cnt_o;
  logic [15:0]       flush_cnt_o;
`endif

  logic [INST_W-1:0] rom [0:DEPTH-1];
  assign inst_i = rom[addr_o];

  inst_fetch #(
    .PC_W      (PC_W),
    .INST_W    (INST_W),
    .LAST_ADDR (LAST_ADDR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .addr_o          (addr_o),
    .inst_i          (inst_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o),
    .halted_o        (halted_o)
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o     (fetch_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
`endif
  );

  typedef struct {
    int addr;
    bit valid;
    bit halted;
    int fcnt;
    int xcnt;
  } status_t;

  typedef struct {
    int pc;
    int inst;
  } fetch_t;

  status_t status_q[$];
  fetch_t  fetch_q[$];

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model state: where fetch is, what IF/ID holds, counters.
  int m_pc;
  bit m_valid;
  bit m_halted;
  int m_fcnt;
  int m_xcnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit br, input int tgt);
    status_t s;
    fetch_t  f;
    rst_n           = rst;
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = PC_W'(tgt);
    if (!rst) begin
      m_pc = 0; m_valid = 0; m_halted = 0; m_fcnt = 0; m_xcnt = 0;
    end else if (br) begin
      m_pc     = tgt % DEPTH;
      m_valid  = 0;
      m_halted = 0;
      if (m_xcnt < 65535) m_xcnt++;
    end else if (st) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 0;
    end else begin
      f.pc   = m_pc;
      f.inst = int'(rom[m_pc]);
      fetch_q.push_back(f);
      m_valid = 1;
      if (m_fcnt < 65535) m_fcnt++;
      if (m_pc == LAST_ADDR) m_halted = 1;
      else m_pc = (m_pc + 1) % DEPTH;
    end
    s.addr = m_pc; s.valid = m_valid; s.halted = m_halted;
    s.fcnt = m_fcnt; s.xcnt = m_xcnt;
    status_q.push_back(s);
    $display("step rst_n=%0b stall=%0b br=%0b tgt=%0d -> exp addr=%0d valid=%0b halted=%0b",
             rst, st, br, tgt, s.addr, s.valid, s.halted);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one status entry per edge; a fetch entry whenever IF/ID is freshly loaded.
  initial begin
    bit e_rst, e_st, e_br;
    status_t s;
    fetch_t  f;
    forever begin
      @(posedge clk);
      if (mon_en) begin
        e_rst = rst_n;
        e_st  = stall_i;
        e_br  = branch_taken_i;
        @(negedge clk);
        if (status_q.size() == 0) begin
          chk("status_q_underflow", 1, 0);
        end else begin
          s = status_q.pop_front();
          chk("addr_o", int'(addr_o), s.addr);
          chk("if_valid_o", int'(if_valid_o), int'(s.valid));
          chk("halted_o", int'(halted_o), int'(s.halted));
`ifdef INST_FETCH_PERF_CNT_EN
          chk("fetch_cnt_o", int'(fetch_cnt_o), s.fcnt);
          chk("flush_cnt_o", int'(flush_cnt_o), s.xcnt);
`endif
        end
        if (e_rst && !e_st && !e_br && if_valid_o) begin
          if (fetch_q.size() == 0) begin
            chk("fetch_q_underflow", int'(if_pc_o), -1);
          end else begin
            f = fetch_q.pop_front();
            chk("if_pc_o", int'(if_pc_o), f.pc);
            chk("if_inst_o", int'(if_inst_o), f.inst);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = (i < 32) ? INST_W'(16'hA000 + i) : INST_W'($urandom);
    end
    rst_n = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    step(0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 20);
    repeat (2) step(1, 0, 0, 0);
    step(1, 1, 1, 3);
    repeat (11) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 1, 2);
    repeat (4) step(1, 0, 0, 0);
    step(1, 0, 1, 45);
    repeat (5) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 120);
    repeat (25) step(1, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 15) == 0),
           int'($urandom_range(0, DEPTH - 1)));
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("fetch_q_drained", fetch_q.size(), 0);
    chk("status_q_drained", status_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
